mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 165 ++++++++++++++++
 tb/tb_mem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Byte-stream loader that assembles MSB-first words and writes them
//            into one of NUM_TARGETS memories, stalling the datapath meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_TARGETS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_TARGETS-1:0] wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   hold,
  output logic                   done,
  output logic                   error
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_BCW   = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
  localparam int c_SW    = (c_BYTES > 1) ? DATA_WIDTH - 8 : 8;
  localparam logic [c_BCW-1:0] c_LAST = c_BCW'(c_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TARGET = 3'd1,
    S_COUNT  = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t                   r_state;
  logic [7:0]               r_target;
  logic [8:0]               r_count;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [c_BCW-1:0]         r_byte_cnt;
  logic [c_SW-1:0]          r_shift;

  logic                     w_xfer;
  logic                     w_id_ok;
  logic [NUM_TARGETS-1:0]   w_sel;
  logic [DATA_WIDTH-1:0]    w_word;

  assign w_xfer  = in_valid & in_ready;
  assign w_id_ok = ({24'd0, in_data} < 32'(NUM_TARGETS));
  assign w_sel   = NUM_TARGETS'(1) << r_target;

  // Word seen so far with the incoming byte appended as the least significant byte.
  generate
    if (c_BYTES == 1) begin : g_byte_word
      assign w_word = in_data;
    end else begin : g_multi_byte_word
      assign w_word = {r_shift[DATA_WIDTH-9:0], in_data};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_target   <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      in_ready   <= 1'b0;
      wr_en      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      hold       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en <= '0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_TARGET;
            hold     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        S_TARGET: begin
          if (w_xfer) begin
            r_target <= in_data;
            if (w_id_ok) begin
              r_state <= S_COUNT;
            end else begin
              r_state  <= S_ERR;
              error    <= 1'b1;
              hold     <= 1'b0;
              in_ready <= 1'b0;
            end
          end
        end
        S_COUNT: begin
          // A count byte of zero encodes the full 256-word load.
          if (w_xfer) begin
            r_count    <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_shift <= w_word[c_SW-1:0];
            if (r_byte_cnt == c_LAST) begin
              r_byte_cnt <= '0;
              r_state    <= S_WRITE;
              in_ready   <= 1'b0;
              wr_en      <= w_sel;
              wr_addr    <= r_addr;
              wr_data    <= w_word;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 1'b1;
          r_count <= r_count - 9'd1;
          if (r_count == 9'd1) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_state  <= S_DATA;
            in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          hold    <= 1'b0;
        end
        S_ERR: begin
          if (start) begin
            r_state  <= S_TARGET;
            error    <= 1'b0;
            hold     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          hold     <= 1'b0;
          in_ready <= 1'b0;
          error    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Self-checking bench for mem_loader against a word-level write model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        hold;
  logic        done;
  logic        error;

  mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_TARGETS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hold(hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]  en;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next write the model predicts.
  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst && wr_en != 3'd0) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr_en", 64'(wr_en), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_en", 64'(wr_en), 64'(e.en));
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, output int acc);
    int guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        acc = cyc;
        in_valid = 1'b0;
        return;
      end
    end
    acc = cyc;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input int tgt, input logic [7:0] cnt, input logic [31:0] words[$], input bit gaps);
    int  nw = (cnt == 8'd0) ? 256 : int'(cnt);
    int  t0, t;
    bit  seen = 1'b0;
    wr_t w;
    pulse_start();
    check("start_hold", 64'(hold), 64'd1);
    check("start_error_clear", 64'(error), 64'd0);
    send_byte(8'(tgt), gaps, t0);
    if (tgt >= 3) begin
      in_valid = 1'b0;
      check("err_flag", 64'(error), 64'd1);
      check("err_hold", 64'(hold), 64'd0);
      check("err_ready", 64'(in_ready), 64'd0);
      return;
    end
    send_byte(cnt, gaps, t);
    for (int i = 0; i < nw; i++) begin
      w.en   = 3'(1 << tgt);
      w.addr = 8'(i);
      w.data = words[i];
      exp_q.push_back(w);
      for (int j = 0; j < 4; j++) send_byte(words[i][31-8*j -: 8], gaps, t);
      in_valid = 1'b0;
      check("wr_timing", 64'(wr_en), 64'(1 << tgt));
    end
    for (int g = 0; g < 8 && !seen; g++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", 64'(seen), 64'd1);
    t = cyc;
    if (!gaps) check("latency", 64'(t - t0 + 1), 64'(2 + nw * 5 + 1));
    check("done_hold", 64'(hold), 64'd1);
    @(negedge clk);
    check("done_single", 64'(done), 64'd0);
    check("hold_drop", 64'(hold), 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] qr[$];
    int          t;
    wr_t         w;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_hold", 64'(hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Bytes offered while idle are not taken.
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (3) @(negedge clk);
    check("idle_ready", 64'(in_ready), 64'd0);
    check("idle_hold", 64'(hold), 64'd0);
    in_valid = 1'b0;

    q = '{32'h0000_0013, 32'h00A0_0093};
    load(2, 8'd2, q, 1'b0);
    load(2, 8'd2, q, 1'b1);

    load(5, 8'd0, q, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h01;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("err_sticky", 64'(error), 64'd1);
    check("err_sticky_ready", 64'(in_ready), 64'd0);
    qr.delete();
    repeat (3) qr.push_back($urandom);
    load(0, 8'd3, qr, 1'b1);

    qr.delete();
    repeat (256) qr.push_back($urandom);
    load(1, 8'd0, qr, 1'b0);

    repeat (6) begin
      qr.delete();
      t = $urandom_range(1, 5);
      repeat (t) qr.push_back($urandom);
      load($urandom_range(0, 2), 8'(t), qr, 1'($urandom_range(0, 1)));
    end

    // Mid-session: an ignored start, then reset after half of word 1.
    qr = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    pulse_start();
    send_byte(8'd2, 1'b0, t);
    send_byte(8'd3, 1'b0, t);
    in_valid = 1'b0;
    pulse_start();
    check("start_ignored_hold", 64'(hold), 64'd1);
    check("start_ignored_ready", 64'(in_ready), 64'd1);
    w.en = 3'b100; w.addr = 8'd0; w.data = qr[0];
    exp_q.push_back(w);
    for (int j = 0; j < 4; j++) send_byte(qr[0][31-8*j -: 8], 1'b0, t);
    send_byte(8'h55, 1'b0, t);
    send_byte(8'h66, 1'b0, t);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data), 64'd0);
    check("mid_rst_hold", 64'(hold), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    check("mid_rst_writes_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("post_rst_hold", 64'(hold), 64'd0);
    load(0, 8'd2, q, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
